// File: rtl/mips_pkg.sv
// Shared opcode constants, forwarding-select encodings and the pipeline tracking
// slot record used by the forwarding/hazard unit.
package mips_pkg;

  localparam logic [5:0] ALUop   = 6'd0;
  localparam logic [5:0] Jop     = 6'd2;
  localparam logic [5:0] JALop   = 6'd3;
  localparam logic [5:0] ADD_IMM = 6'd8;
  localparam logic [5:0] LW      = 6'd35;
  localparam logic [5:0] SW      = 6'd43;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } slot_t;

  localparam slot_t BUBBLE = '{op: 6'd0, rs: 5'd0, rt: 5'd0, dest: 5'd0, wr: 1'b0, ld: 1'b0};

  function automatic logic uses_rs(input logic [5:0] op);
    case (op)
      ALUop, LW, ADD_IMM, SW: uses_rs = 1'b1;
      default:                uses_rs = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    case (op)
      ALUop, SW: uses_rt = 1'b1;
      default:   uses_rt = 1'b0;
    endcase
  endfunction

  // Instructions without a destination report has_dest=0 so they never forward.
  function automatic slot_t decode(input logic [31:0] ir);
    slot_t s;
    logic  has_dest;
    s.op     = ir[31:26];
    s.rs     = ir[25:21];
    s.rt     = ir[20:16];
    has_dest = 1'b1;
    case (ir[31:26])
      ALUop:       s.dest = ir[15:11];
      LW, ADD_IMM: s.dest = ir[20:16];
      JALop:       s.dest = 5'd31;
      default: begin
        s.dest   = 5'd0;
        has_dest = 1'b0;
      end
    endcase
    s.wr   = has_dest && (s.dest != 5'd0);
    s.ld   = (ir[31:26] == LW);
    decode = s;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority compare for one ALU operand: the younger EX/MEM result wins over MEM/WB.
module fwd_sel
  import mips_pkg::*;
(
  input  logic       en,
  input  logic [4:0] src,
  input  logic       exmem_wr,
  input  logic [4:0] exmem_dest,
  input  logic       memwb_wr,
  input  logic [4:0] memwb_dest,
  output logic [1:0] sel
);

  // Select the forwarding source for this operand.
  always_comb begin
    sel = SEL_REG;
    if (en && exmem_wr && (exmem_dest == src)) begin
      sel = SEL_MEM;
    end else if (en && memwb_wr && (memwb_dest == src)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_REG;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks ID/EX, EX/MEM and MEM/WB register
// usage, drives ALU operand selects and a one-cycle load-use interlock.
module fwd_hazard_unit
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ifid_ir,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fa,
  output logic [1:0]  fb,
  output logic [5:0]  idex_op,
  output logic [15:0] stall_count
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE_ST = 1'b1;

  slot_t      id_s;
  slot_t      idex_r;
  slot_t      exmem_r;
  slot_t      memwb_r;
  logic [0:0] state_r;
  logic       stall_s;

  assign id_s = decode(ifid_ir);

  // Load-use interlock; a squashed ID instruction can never need to wait.
  always_comb begin
    stall_s = 1'b0;
    if (!flush && (state_r == RUN) && idex_r.ld && (idex_r.dest != 5'd0) &&
        ((uses_rs(id_s.op) && (idex_r.dest == id_s.rs)) ||
         (uses_rt(id_s.op) && (idex_r.dest == id_s.rt)))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Advance the tracking slots; ID/EX takes a bubble when stalled or flushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_r  <= BUBBLE;
      exmem_r <= BUBBLE;
      memwb_r <= BUBBLE;
    end else begin
      memwb_r <= exmem_r;
      exmem_r <= idex_r;
      idex_r  <= (stall_s || flush) ? BUBBLE : id_s;
    end
  end

  // RUN/BUBBLE sequencing bounds each load-use stall to a single cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN:       state_r <= stall_s ? BUBBLE_ST : RUN;
        BUBBLE_ST: state_r <= RUN;
        default:   state_r <= RUN;
      endcase
    end
  end

  // Saturating stall cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (stall_s && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end else begin
      stall_count <= stall_count;
    end
  end

  fwd_sel u_sel_a (
    .en         (uses_rs(idex_r.op)),
    .src        (idex_r.rs),
    .exmem_wr   (exmem_r.wr),
    .exmem_dest (exmem_r.dest),
    .memwb_wr   (memwb_r.wr),
    .memwb_dest (memwb_r.dest),
    .sel        (fa)
  );

  fwd_sel u_sel_b (
    .en         (uses_rt(idex_r.op)),
    .src        (idex_r.rt),
    .exmem_wr   (exmem_r.wr),
    .exmem_dest (exmem_r.dest),
    .memwb_wr   (memwb_r.wr),
    .memwb_dest (memwb_r.dest),
    .sel        (fb)
  );

  assign stall   = stall_s;
  assign idex_op = idex_r.op;

endmodule
